circular_bist_rr_arbiter: RTL and testbench

- N-channel round-robin arbiter with built-in circular BIST. Parametrised successor of the fixed 4-request, 16-bit-signature arbiter/BIST top.
- In functional mode it arbitrates external requests.
- In test mode a circular register (CR) drives the arbiter inputs and compacts the grants every cycle. The final CR value is compared against a golden signature.
- Instantiated directly under the top-level testbench. Start/end/pass handshake is unchanged from the previous generation.

---
 rtl/circular_bist_rr_arbiter.sv | 117 +++++++++++
 tb/tb_circular_bist_rr_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/circular_bist_rr_arbiter.sv
// Round-robin arbiter with circular BIST: in test mode a rotating signature register
// feeds the arbiter and folds the resulting grants back into itself.
module circular_bist_rr_arbiter #(
    parameter int unsigned      N        = 4,
    parameter int unsigned      SIG_W    = 16,
    parameter int unsigned      TEST_LEN = 64,
    parameter logic [SIG_W-1:0] SEED     = 16'hFFFF,
    parameter logic [SIG_W-1:0] GOLDEN   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     request,
    output logic [N-1:0]     grant_o,
    input  logic             bist_start,
    output logic             bist_end,
    output logic             pass_fail,
    output logic [SIG_W-1:0] signature_out
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(TEST_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_COMPARE, S_DONE} state_t;

    state_t           state;
    logic [SIG_W-1:0] cr;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;
    logic             start_q;
    logic             start_pulse;
    logic [N-1:0]     arb_in;
    logic [N-1:0]     arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic [PW-1:0]    pos;
    logic             arb_hit;
    logic [SIG_W-1:0] d;
    logic [SIG_W-1:0] cr_step;

    assign start_pulse   = bist_start & ~start_q;
    assign signature_out = cr;

    always_comb begin
        case (state)
            S_IDLE, S_DONE: arb_in = request;
            S_RUN:          arb_in = cr[N-1:0];
            default:        arb_in = '0;
        endcase
    end

    // Search starts just above the last winner and wraps, so the previous winner is lowest priority.
    always_comb begin
        arb_gnt = '0;
        arb_idx = ptr;
        arb_hit = 1'b0;
        pos     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = PW'((32'(ptr) + k) % N);
            if (!arb_hit && arb_in[pos]) begin
                arb_hit = 1'b1;
                arb_idx = pos;
            end
        end
        if (arb_hit) arb_gnt[arb_idx] = 1'b1;
    end

    always_comb begin
        d          = '0;
        d[N-1:0]   = grant_o;
        cr_step    = {cr[SIG_W-2:0], cr[SIG_W-1]} ^ d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            cr        <= '0;
            ptr       <= PW'(N - 1);
            cnt       <= '0;
            start_q   <= 1'b0;
            grant_o   <= '0;
            bist_end  <= 1'b0;
            pass_fail <= 1'b0;
        end else begin
            start_q <= bist_start;
            grant_o <= arb_gnt;
            if (arb_hit) ptr <= arb_idx;
            case (state)
                S_IDLE: begin
                    if (start_pulse) state <= S_INIT;
                end
                S_INIT: begin
                    cr        <= SEED;
                    cnt       <= '0;
                    ptr       <= PW'(N - 1);
                    grant_o   <= '0;
                    bist_end  <= 1'b0;
                    pass_fail <= 1'b0;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    cr  <= cr_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(TEST_LEN - 1)) state <= S_COMPARE;
                end
                S_COMPARE: begin
                    pass_fail <= (cr == GOLDEN);
                    state     <= S_DONE;
                end
                S_DONE: begin
                    bist_end <= 1'b1;
                    if (start_pulse) state <= S_INIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_circular_bist_rr_arbiter.sv
// Bench for circular_bist_rr_arbiter: timeline-based reference model checked every
// cycle, plus directed sessions with hand-computed grants, latencies and signatures.
module tb_circular_bist_rr_arbiter;

    typedef struct {
        int          p;     // 0: no session; else index of upcoming edge since accepted start
        int          ptr;
        int unsigned cr;
        int unsigned g;
        bit          be;
        bit          pf;
        bit          sq;
    } mdl_t;

    function automatic int arb_pick(int unsigned v, int ptr, int n);
        int pick = -1;
        for (int k = 1; k <= n; k++) begin
            if (pick < 0 && ((v >> ((ptr + k) % n)) & 32'd1) != 0) pick = (ptr + k) % n;
        end
        return pick;
    endfunction

    function automatic int unsigned rotl(int unsigned v, int sw);
        int unsigned mask = (32'd1 << sw) - 32'd1;
        return ((v << 1) | (v >> (sw - 1))) & mask;
    endfunction

    function automatic int unsigned sig_ref(int n, int sw, int tl, int unsigned seed);
        int unsigned cr    = seed;
        int unsigned g     = 0;
        int unsigned nmask = (32'd1 << n) - 32'd1;
        int          ptr   = n - 1;
        int          pick;
        for (int t = 0; t < tl; t++) begin
            pick = arb_pick(cr & nmask, ptr, n);
            cr   = rotl(cr, sw) ^ g;
            g    = (pick < 0) ? 0 : (32'd1 << pick);
            if (pick >= 0) ptr = pick;
        end
        return cr;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int n, int sw, int tl, int unsigned seed,
                                   int unsigned golden, bit rst, bit bs, int unsigned req);
        mdl_t        r;
        int unsigned nmask = (32'd1 << n) - 32'd1;
        int unsigned ain;
        int          pick;
        bit          ext, run;
        if (rst) begin
            r.p = 0; r.ptr = n - 1; r.cr = 0; r.g = 0; r.be = 0; r.pf = 0; r.sq = 0;
            return r;
        end
        r    = m;
        ext  = (m.p == 0) || (m.p >= tl + 3);
        run  = (m.p >= 2) && (m.p <= tl + 1);
        ain  = ext ? (req & nmask) : (run ? (m.cr & nmask) : 0);
        pick = arb_pick(ain, m.ptr, n);
        r.g  = (pick < 0) ? 0 : (32'd1 << pick);
        if (pick >= 0) r.ptr = pick;
        if (run) r.cr = rotl(m.cr, sw) ^ m.g;
        if (m.p == 1) begin
            r.cr = seed; r.ptr = n - 1; r.g = 0; r.be = 0; r.pf = 0;
        end
        if (m.p == tl + 2) r.pf = (m.cr == golden);
        if (m.p >= tl + 3) r.be = 1;
        if (ext && bs && !m.sq)  r.p = 1;
        else if (m.p == 0)       r.p = 0;
        else if (m.p >= tl + 3)  r.p = tl + 3;
        else                     r.p = m.p + 1;
        r.sq = bs;
        return r;
    endfunction

    localparam int unsigned SIG_NOM = sig_ref(4, 16, 64, 32'hFFFF);

    logic        clk = 1'b0;
    logic        reset, bist_start, bist_start_b;
    logic [3:0]  request;
    logic [7:0]  request_b;
    logic [3:0]  u0_g, u1_g, u2_g;
    logic [7:0]  u3_g;
    logic        u0_be, u1_be, u2_be, u3_be;
    logic        u0_pf, u1_pf, u2_pf, u3_pf;
    logic [15:0] u0_sig, u1_sig, u2_sig;
    logic [11:0] u3_sig;

    mdl_t m0, m1, m2, m3;
    int   n_chk = 0;
    int   n_err = 0;
    bit   chk_en = 0;

    always #5 clk = ~clk;

    circular_bist_rr_arbiter u0 (
        .clock(clk), .reset(reset), .request(request), .grant_o(u0_g), .bist_start(bist_start),
        .bist_end(u0_be), .pass_fail(u0_pf), .signature_out(u0_sig));

    circular_bist_rr_arbiter #(.GOLDEN(16'(SIG_NOM))) u1 (
        .clock(clk), .reset(reset), .request(request), .grant_o(u1_g), .bist_start(bist_start),
        .bist_end(u1_be), .pass_fail(u1_pf), .signature_out(u1_sig));

    circular_bist_rr_arbiter #(.GOLDEN(16'(SIG_NOM ^ 32'd1))) u2 (
        .clock(clk), .reset(reset), .request(request), .grant_o(u2_g), .bist_start(bist_start),
        .bist_end(u2_be), .pass_fail(u2_pf), .signature_out(u2_sig));

    circular_bist_rr_arbiter #(.N(8), .SIG_W(12), .TEST_LEN(5), .SEED(12'h5A3), .GOLDEN(12'h000)) u3 (
        .clock(clk), .reset(reset), .request(request_b), .grant_o(u3_g), .bist_start(bist_start_b),
        .bist_end(u3_be), .pass_fail(u3_pf), .signature_out(u3_sig));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        m0 <= mstep(m0, 4, 16, 64, 32'hFFFF, 32'd0, reset, bist_start, 32'(request));
        m1 <= mstep(m1, 4, 16, 64, 32'hFFFF, SIG_NOM, reset, bist_start, 32'(request));
        m2 <= mstep(m2, 4, 16, 64, 32'hFFFF, SIG_NOM ^ 32'd1, reset, bist_start, 32'(request));
        m3 <= mstep(m3, 8, 12, 5, 32'h5A3, 32'd0, reset, bist_start_b, 32'(request_b));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("u0_grant", 32'(u0_g), m0.g);
            check("u0_bist_end", 32'(u0_be), 32'(m0.be));
            check("u0_pass_fail", 32'(u0_pf), 32'(m0.pf));
            check("u0_signature", 32'(u0_sig), m0.cr);
            check("u1_pass_fail", 32'(u1_pf), 32'(m1.pf));
            check("u2_pass_fail", 32'(u2_pf), 32'(m2.pf));
            check("u3_grant", 32'(u3_g), m3.g);
            check("u3_bist_end", 32'(u3_be), 32'(m3.be));
            check("u3_pass_fail", 32'(u3_pf), 32'(m3.pf));
            check("u3_signature", 32'(u3_sig), m3.cr);
        end
    end

    // mode 0: quiet; 1: random requests plus a second start edge mid-RUN; 2: random requests only
    task automatic session(input int which, input int mode, output int lat);
        int e = 0;
        bit seen_low = 0;
        bit done = 0;
        bit st, be;
        lat = -1;
        if (which == 0) bist_start = 1'b1; else bist_start_b = 1'b1;
        while (!done && e < 300) begin
            tick;
            e++;
            st = (e < 3) || (mode == 1 && e >= 12 && e < 15);
            if (which == 0) bist_start = st; else bist_start_b = st;
            if (mode != 0) begin
                request   = 4'($urandom);
                request_b = 8'($urandom);
            end
            be = (which == 0) ? u0_be : u3_be;
            if (!be) seen_low = 1;
            else if (seen_low) begin
                done = 1;
                lat  = e - 1;
            end
        end
        request = '0; request_b = '0; bist_start = 1'b0; bist_start_b = 1'b0;
        check("session_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int lat;
        reset = 1'b1; bist_start = 1'b0; bist_start_b = 1'b0; request = '0; request_b = '0;
        tick;
        chk_en = 1;
        tick;
        check("rst_grant", 32'(u0_g), 32'd0);
        check("rst_bist_end", 32'(u0_be), 32'd0);
        check("rst_pass_fail", 32'(u0_pf), 32'd0);
        check("rst_signature", 32'(u0_sig), 32'd0);
        check("rst_u3_signature", 32'(u3_sig), 32'd0);
        reset = 1'b0;

        request = 4'b1010;
        tick; check("rr_grant_1", 32'(u0_g), 32'b0010);
        tick; check("rr_grant_2", 32'(u0_g), 32'b1000);
        tick; check("rr_grant_3", 32'(u0_g), 32'b0010);
        request = 4'b0000;
        tick; check("rr_grant_idle", 32'(u0_g), 32'b0000);
        request = 4'b1111;
        tick; check("rr_grant_ptr_held", 32'(u0_g), 32'b0100);
        request = 4'b0000;
        tick;

        session(0, 0, lat);
        check("lat_quiet", 32'(lat), 32'd67);
        check("sig_quiet", 32'(u0_sig), SIG_NOM);
        check("pf_golden_match", 32'(u1_pf), 32'd1);
        check("pf_golden_flip", 32'(u2_pf), 32'd0);

        session(0, 1, lat);
        check("lat_noisy", 32'(lat), 32'd67);
        check("sig_noisy", 32'(u0_sig), SIG_NOM);
        check("pf_noisy_match", 32'(u1_pf), 32'd1);

        bist_start = 1'b1;
        repeat (3) tick;
        bist_start = 1'b0;
        repeat (18) tick;
        reset = 1'b1;
        tick;
        check("abort_grant", 32'(u0_g), 32'd0);
        check("abort_bist_end", 32'(u0_be), 32'd0);
        check("abort_pass_fail", 32'(u1_pf), 32'd0);
        check("abort_signature", 32'(u0_sig), 32'd0);
        reset = 1'b0;
        tick;
        session(0, 0, lat);
        check("lat_after_abort", 32'(lat), 32'd67);
        check("sig_after_abort", 32'(u0_sig), SIG_NOM);

        session(1, 0, lat);
        check("n8_lat", 32'(lat), 32'd8);
        check("n8_sig", 32'(u3_sig), 32'h46B);
        check("n8_pass_fail", 32'(u3_pf), 32'd0);
        session(1, 2, lat);
        check("n8_lat_b2b", 32'(lat), 32'd8);
        check("n8_sig_b2b", 32'(u3_sig), 32'h46B);

        repeat (2) tick;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
